// File: rtl/noc_pkg.sv
// Shared NoC router types: flit layout, QoS level and the router-wide VC count.
package noc_pkg;

    localparam int VC_COUNT  = 4;
    localparam int QOS_W     = 2;
    localparam int DEST_W    = 4;
    localparam int PAYLOAD_W = 24;

    typedef logic [QOS_W-1:0] qos_level_t;

    typedef struct packed {
        qos_level_t        qos;
        logic [DEST_W-1:0] dest;
    } noc_header_t;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        noc_header_t          header;
        logic [PAYLOAD_W-1:0] payload;
    } noc_flit_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single virtual-channel flit FIFO with a combinational head and an occupancy count.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module noc_vc_fifo
    import noc_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  noc_flit_t        din,
    output noc_flit_t        head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    noc_flit_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Router input-port VC buffer: per-VC FIFOs, switch-allocator grant consumer,
// one registered upstream credit per dequeued flit, and sticky error flags.
module noc_input_vc_buffer
    import noc_pkg::*;
#(
    parameter int  VC_COUNT = noc_pkg::VC_COUNT,
    parameter int  DEPTH    = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int VC_W     = $clog2(VC_COUNT)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_flit_valid,
    input  logic [VC_W-1:0]                    in_flit_vc,
    input  noc_flit_t                          in_flit,
    input  logic [VC_COUNT-1:0]                grant,
    output logic [VC_COUNT-1:0]                buffer_empty,
    output noc_flit_t [VC_COUNT-1:0]           head_flit,
    output logic [VC_COUNT-1:0][CNT_W-1:0]     occupancy,
    output logic                               credit_valid,
    output logic [VC_W-1:0]                    credit_vc,
    output logic                               overflow_err,
    output logic                               grant_err
);

    logic [VC_COUNT-1:0] vc_sel;
    logic [VC_COUNT-1:0] push;
    logic [VC_COUNT-1:0] pop;
    logic [VC_COUNT-1:0] full;
    logic [VC_COUNT-1:0] empty;
    logic                grant_ok;
    logic                grant_bad;
    logic                overflow_hit;
    logic [VC_W-1:0]     pop_idx;

    logic            credit_valid_q, credit_valid_d;
    logic [VC_W-1:0] credit_vc_q, credit_vc_d;
    logic            overflow_err_q, overflow_err_d;
    logic            grant_err_q, grant_err_d;

    // A grant is honoured only if it is one-hot and lands on a VC that was
    // non-empty before this edge; anything else non-zero is an error.
    always_comb begin
        vc_sel             = '0;
        vc_sel[in_flit_vc] = in_flit_valid;
        grant_ok           = $onehot(grant) && ((grant & ~empty) != '0);
        grant_bad          = (grant != '0) && !grant_ok;
        pop                = grant_ok ? grant : '0;
        push               = vc_sel & (~full | pop);
        overflow_hit       = (vc_sel & full & ~pop) != '0;
        pop_idx            = '0;
        for (int v = 0; v < VC_COUNT; v++) begin
            if (pop[v]) pop_idx = VC_W'(v);
        end
    end

    always_comb begin
        credit_valid_d = |pop;
        credit_vc_d    = (|pop) ? pop_idx : credit_vc_q;
        overflow_err_d = overflow_err_q | overflow_hit;
        grant_err_d    = grant_err_q | grant_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            overflow_err_q <= 1'b0;
            grant_err_q    <= 1'b0;
        end else begin
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            overflow_err_q <= overflow_err_d;
            grant_err_q    <= grant_err_d;
        end
    end

    for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
        noc_vc_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (in_flit),
            .head  (head_flit[v]),
            .empty (empty[v]),
            .full  (full[v]),
            .count (occupancy[v])
        );
    end

    assign buffer_empty = empty;
    assign credit_valid = credit_valid_q;
    assign credit_vc    = credit_vc_q;
    assign overflow_err = overflow_err_q;
    assign grant_err    = grant_err_q;

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Self-checking bench for noc_input_vc_buffer: per-VC queue model plus a credit scoreboard.
module tb_noc_input_vc_buffer;
    import noc_pkg::*;

    localparam int VCN   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                          clk;
    logic                          rst_n;
    logic                          in_flit_valid;
    logic [1:0]                    in_flit_vc;
    noc_flit_t                     in_flit;
    logic [VCN-1:0]                grant;
    logic [VCN-1:0]                buffer_empty;
    noc_flit_t [VCN-1:0]           head_flit;
    logic [VCN-1:0][CNT_W-1:0]     occupancy;
    logic                          credit_valid;
    logic [1:0]                    credit_vc;
    logic                          overflow_err;
    logic                          grant_err;

    noc_input_vc_buffer #(.VC_COUNT(VCN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_flit_valid (in_flit_valid),
        .in_flit_vc    (in_flit_vc),
        .in_flit       (in_flit),
        .grant         (grant),
        .buffer_empty  (buffer_empty),
        .head_flit     (head_flit),
        .occupancy     (occupancy),
        .credit_valid  (credit_valid),
        .credit_vc     (credit_vc),
        .overflow_err  (overflow_err),
        .grant_err     (grant_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    noc_flit_t  mq [VCN][$];
    logic [1:0] exp_q [$];
    logic       exp_ovf;
    logic       exp_gerr;
    int         n_pass;
    int         n_total;
    int         pops_made;
    int         credits_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic noc_flit_t rand_flit();
        return noc_flit_t'($urandom());
    endfunction

    task automatic clear_model();
        for (int i = 0; i < VCN; i++) mq[i].delete();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_gerr = 1'b0;
    endtask

    task automatic idle_inputs();
        in_flit_valid = 1'b0;
        in_flit_vc    = '0;
        in_flit       = '0;
        grant         = '0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: check visible state, update the model, drive, then
    // check the registered credit and error flags after the edge.
    task automatic step(input logic v, input logic [1:0] vc, input noc_flit_t f, input logic [3:0] g);
        logic       do_pop;
        logic [1:0] pv;
        int         sz;
        for (int i = 0; i < VCN; i++) begin
            check($sformatf("empty[%0d]", i), buffer_empty[i], mq[i].size() == 0);
            check($sformatf("occupancy[%0d]", i), occupancy[i], mq[i].size());
            if (mq[i].size() != 0) check($sformatf("head[%0d]", i), head_flit[i], mq[i][0]);
        end
        do_pop = 1'b0;
        pv     = '0;
        if ($onehot(g)) begin
            for (int i = 0; i < VCN; i++) begin
                if (g[i] && mq[i].size() != 0) begin
                    do_pop = 1'b1;
                    pv     = 2'(i);
                end
            end
            if (!do_pop) exp_gerr = 1'b1;
        end else if (g != '0) begin
            exp_gerr = 1'b1;
        end
        sz = mq[vc].size();
        if (do_pop) begin
            void'(mq[pv].pop_front());
            exp_q.push_back(pv);
            pops_made++;
        end
        if (v) begin
            if (sz < DEPTH || (do_pop && pv == vc)) mq[vc].push_back(f);
            else exp_ovf = 1'b1;
        end
        in_flit_valid = v;
        in_flit_vc    = vc;
        in_flit       = f;
        grant         = g;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check("credit_valid", credit_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            if (credit_valid) begin
                check("credit_vc", credit_vc, exp_q[0]);
                credits_seen++;
            end
            void'(exp_q.pop_front());
        end
        check("overflow_err", overflow_err, exp_ovf);
        check("grant_err", grant_err, exp_gerr);
    endtask

    noc_flit_t f0;
    noc_flit_t f4;

    initial begin
        n_pass       = 0;
        n_total      = 0;
        pops_made    = 0;
        credits_seen = 0;
        rst_n        = 1'b0;
        idle_inputs();
        clear_model();
        #12;
        check("rst_empty", buffer_empty, 4'hF);
        for (int i = 0; i < VCN; i++) check($sformatf("rst_occ[%0d]", i), occupancy[i], 0);
        check("rst_credit_valid", credit_valid, 0);
        check("rst_credit_vc", credit_vc, 0);
        check("rst_overflow_err", overflow_err, 0);
        check("rst_grant_err", grant_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill VC2, then overflow it with no pop
        f0 = rand_flit();
        step(1'b1, 2'd2, f0, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, rand_flit(), 4'b0000);
        check("fill_empty", buffer_empty, 4'b1011);
        check("fill_occ2", occupancy[2], 4);
        check("fill_head2", head_flit[2], f0);
        check("fill_no_credit", credit_valid, 0);
        f4 = rand_flit();
        while (f4 == f0) f4 = rand_flit();
        step(1'b1, 2'd2, f4, 4'b0000);
        check("ovf_flag", overflow_err, 1);
        check("ovf_occ2", occupancy[2], 4);
        check("ovf_head2", head_flit[2], f0);

        // drain VC2 in order
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 4'b0100);
        check("drain_empty2", buffer_empty[2], 1);

        // full VC1 with simultaneous write and pop
        reset_all();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, rand_flit(), 4'b0000);
        step(1'b1, 2'd1, rand_flit(), 4'b0010);
        check("fullpop_occ1", occupancy[1], 4);
        check("fullpop_ovf", overflow_err, 0);

        // illegal grants, and a write to empty VC3 that cannot be popped in the same cycle
        step(1'b1, 2'd0, rand_flit(), 4'b0000);
        step(1'b0, 2'd0, '0, 4'b0011);
        check("gerr_multi", grant_err, 1);
        step(1'b0, 2'd0, '0, 4'b1000);
        step(1'b1, 2'd3, rand_flit(), 4'b1000);
        step(1'b0, 2'd0, '0, 4'b1000);
        step(1'b0, 2'd0, '0, 4'b0000);

        // random legal traffic
        reset_all();
        for (int n = 0; n < 300; n++) begin
            int       k;
            logic [3:0] g;
            k = $urandom_range(0, VCN - 1);
            g = '0;
            if ($urandom_range(0, 3) != 0 && mq[k].size() != 0) g = 4'(1 << k);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, VCN - 1)), rand_flit(), g);
        end
        while (exp_q.size() != 0) step(1'b0, 2'd0, '0, 4'b0000);

        // reset in the middle of traffic with a credit outstanding
        reset_all();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, rand_flit(), 4'b0000);
        step(1'b0, 2'd0, '0, 4'b1000);
        grant = 4'b0001;
        @(posedge clk);
        #1;
        grant = '0;
        check("pre_rst_credit", credit_valid, 1);
        check("pre_rst_occ0", occupancy[0], 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", buffer_empty, 4'hF);
        check("mid_rst_occ0", occupancy[0], 0);
        check("mid_rst_credit", credit_valid, 0);
        check("mid_rst_gerr", grant_err, 0);
        check("mid_rst_ovf", overflow_err, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd2, rand_flit(), 4'b0000);
        step(1'b0, 2'd0, '0, 4'b0100);
        step(1'b0, 2'd0, '0, 4'b0000);

        check("scoreboard_drained", exp_q.size(), 0);
        check("credits_eq_pops", credits_seen, pops_made);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
